// File: rtl/mem_access_unit_pkg.sv
// Shared load/store opcodes, FSM states and byte-enable patterns
// for the memory access stage.
package mem_access_unit_pkg;

  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

  localparam logic [3:0] DMEM_BE_NONE = 4'b0000;
  localparam logic [3:0] DMEM_BE_BYTE = 4'b0001;
  localparam logic [3:0] DMEM_BE_HALF = 4'b0011;
  localparam logic [3:0] DMEM_BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  function automatic logic is_load(input logic [5:0] c);
    return c inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
  endfunction

  function automatic logic is_store(input logic [5:0] c);
    return c inside {ALU_SB, ALU_SH, ALU_SW};
  endfunction

  function automatic mem_size_t op_size(input logic [5:0] c);
    if (c inside {ALU_LB, ALU_LBU, ALU_SB}) return SZ_B;
    if (c inside {ALU_LH, ALU_LHU, ALU_SH}) return SZ_H;
    return SZ_W;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Execute-side request, data-memory port and writeback response
// of the memory access stage, bundled as one interface.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  alucode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport slave (
    input  req_valid, alucode, addr, wdata,
    input  dmem_ack, dmem_rdata,
    output req_ready,
    output dmem_req, dmem_we, dmem_be,
    output dmem_addr, dmem_wdata,
    output resp_valid, resp_data, resp_err
  );

  modport master (
    output req_valid, alucode, addr, wdata,
    output dmem_ack, dmem_rdata,
    input  req_ready,
    input  dmem_req, dmem_we, dmem_be,
    input  dmem_addr, dmem_wdata,
    input  resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the loaded byte/half from a read word and sign- or
// zero-extends it; words and non-loads pass the word through.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [5:0]  alucode,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[8*lane +: 8];
    h    = rdata[16*lane[1] +: 16];
    data = rdata;
    unique case (1'b1)
      alucode == ALU_LB:  data = {{24{b[7]}}, b};
      alucode == ALU_LBU: data = {24'b0, b};
      alucode == ALU_LH:  data = {{16{h[15]}}, h};
      alucode == ALU_LHU: data = {16'b0, h};
      default:            data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: req/ack data-memory access with timeout.
// MEM_ALIGN_TRAP_EN: trap misaligned accesses instead of masking.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_unit_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mem_state_t  state, state_nxt;
  mem_size_t   sz;
  logic [CW-1:0] cnt;
  logic [5:0]  op_q;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  be_d;
  logic [31:0] wd_d, ext;
  logic        accept, trap, timeout;

  assign bus.req_ready  = (state == MEM_IDLE);
  assign bus.dmem_req   = (state == MEM_REQ);
  assign bus.resp_valid = (state == MEM_RESP);

  always_comb begin
    sz     = op_size(bus.alucode);
    accept = bus.req_valid && (state == MEM_IDLE) &&
             (is_load(bus.alucode) || is_store(bus.alucode));
`ifdef MEM_ALIGN_TRAP_EN
    lane_d = bus.addr[1:0];
    trap   = ((sz == SZ_H) && bus.addr[0]) ||
             ((sz == SZ_W) && (|bus.addr[1:0]));
`else
    trap   = 1'b0;
    lane_d = bus.addr[1:0];
    if (sz == SZ_H) lane_d = {bus.addr[1], 1'b0};
    if (sz == SZ_W) lane_d = 2'b00;
`endif
    be_d = DMEM_BE_WORD;
    wd_d = bus.wdata;
    unique case (sz)
      SZ_B: begin
        be_d = DMEM_BE_BYTE << lane_d;
        wd_d = {4{bus.wdata[7:0]}};
      end
      SZ_H: begin
        be_d = DMEM_BE_HALF << {lane_d[1], 1'b0};
        wd_d = {2{bus.wdata[15:0]}};
      end
      default: begin
        be_d = DMEM_BE_WORD;
        wd_d = bus.wdata;
      end
    endcase
    timeout = (cnt == CW'(TIMEOUT - 1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MEM_IDLE:
        if (accept) state_nxt = trap ? MEM_RESP : MEM_REQ;
      MEM_REQ:
        if (bus.dmem_ack || timeout) state_nxt = MEM_RESP;
      default:
        state_nxt = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MEM_IDLE;
    else        state <= state_nxt;
  end

  load_extend u_ext (
    .alucode (op_q),
    .lane    (lane_q),
    .rdata   (bus.dmem_rdata),
    .data    (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      op_q           <= '0;
      lane_q         <= '0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_be    <= DMEM_BE_NONE;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
    end else if (accept) begin
      cnt            <= '0;
      op_q           <= bus.alucode;
      lane_q         <= lane_d;
      bus.dmem_we    <= is_store(bus.alucode);
      bus.dmem_be    <= be_d;
      bus.dmem_addr  <= {bus.addr[31:2], 2'b00};
      bus.dmem_wdata <= wd_d;
      bus.resp_data  <= '0;
      bus.resp_err   <= trap;
    end else if (state == MEM_REQ) begin
      cnt <= cnt + 1'b1;
      // ack wins over a timeout landing in the same cycle
      if (bus.dmem_ack) begin
        bus.resp_data <= bus.dmem_we ? '0 : ext;
        bus.resp_err  <= 1'b0;
      end else if (timeout) begin
        bus.resp_data <= '0;
        bus.resp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a spec-level model sets
// expectations, a negedge process compares every cycle.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic        chk_en = 1'b0;
  logic        exp_ready, exp_dreq, exp_rv, exp_we, exp_err;
  logic [3:0]  exp_be;
  logic [31:0] exp_daddr, exp_dwd, exp_data;

  logic [31:0] seen_data, seen_addr, seen_wd;
  logic [3:0]  seen_be;
  logic        seen_err, seen_we;
  int          seen_rv_cyc;
  int          dreq_cnt;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("dmem_req", 32'(bus.dmem_req), 32'(exp_dreq));
      check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      if (exp_dreq) begin
        check("dmem_we", 32'(bus.dmem_we), 32'(exp_we));
        check("dmem_be", 32'(bus.dmem_be), 32'(exp_be));
        check("dmem_addr", bus.dmem_addr, exp_daddr);
        check("dmem_wdata", bus.dmem_wdata, exp_dwd);
      end
      if (exp_rv) begin
        check("resp_data", bus.resp_data, exp_data);
        check("resp_err", 32'(bus.resp_err), 32'(exp_err));
      end
    end
    if (bus.resp_valid === 1'b1) begin
      seen_data   = bus.resp_data;
      seen_err    = bus.resp_err;
      seen_rv_cyc = cyc;
    end
    if (bus.dmem_req === 1'b1) begin
      dreq_cnt++;
      seen_be   = bus.dmem_be;
      seen_addr = bus.dmem_addr;
      seen_wd   = bus.dmem_wdata;
      seen_we   = bus.dmem_we;
    end
  end

  function automatic void model(
    input  logic [5:0]  op,
    input  logic [31:0] a, wd, rd,
    output logic        trap,
    output logic [3:0]  be,
    output logic [31:0] daddr, dwd, res
  );
    logic [31:0] sz, ea, lane, m, v, t;
    logic        st, sgn;
    sz = 32'd4;
    if (op == ALU_LB || op == ALU_LBU || op == ALU_SB) sz = 32'd1;
    if (op == ALU_LH || op == ALU_LHU || op == ALU_SH) sz = 32'd2;
    st  = (op == ALU_SB || op == ALU_SH || op == ALU_SW);
    sgn = (op == ALU_LB || op == ALU_LH);
`ifdef MEM_ALIGN_TRAP_EN
    trap = (a % sz) != 0;
    ea   = a;
`else
    trap = 1'b0;
    ea   = a - (a % sz);
`endif
    lane  = ea % 32'd4;
    t     = ((32'd1 << sz) - 32'd1) << lane;
    be    = t[3:0];
    daddr = a - (a % 32'd4);
    if (sz == 32'd1)      dwd = (wd & 32'hFF) * 32'h01010101;
    else if (sz == 32'd2) dwd = (wd & 32'hFFFF) * 32'h00010001;
    else                  dwd = wd;
    m = (sz == 32'd1) ? 32'hFF : (sz == 32'd2) ? 32'hFFFF : 32'hFFFF_FFFF;
    v = (rd >> (32'd8 * lane)) & m;
    if (sgn && v > (m >> 1)) v = v | ~m;
    res = (st || trap) ? 32'd0 : v;
  endfunction

  task automatic set_idle();
    exp_ready = 1'b1;
    exp_dreq  = 1'b0;
    exp_rv    = 1'b0;
    exp_err   = 1'b0;
  endtask

  task automatic clear_seen();
    seen_data   = 'x;
    seen_addr   = 'x;
    seen_wd     = 'x;
    seen_be     = 'x;
    seen_err    = 1'bx;
    seen_we     = 1'bx;
    seen_rv_cyc = -1;
    dreq_cnt    = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // k = cycle (1..TO) in which ack is driven, 0 for never
  task automatic do_op(input logic [5:0] opc,
                       input logic [31:0] a, wd,
                       input int k,
                       input logic [31:0] rd);
    logic trap, tmo;
    logic [31:0] res;
    model(opc, a, wd, rd, trap, exp_be, exp_daddr, exp_dwd, res);
    exp_we = (opc == ALU_SB || opc == ALU_SH || opc == ALU_SW);
    clear_seen();
    cyc = 0;
    bus.req_valid = 1'b1;
    bus.alucode   = opc;
    bus.addr      = a;
    bus.wdata     = wd;
    set_idle();
    tick();
    bus.req_valid = 1'b0;
    exp_ready = 1'b0;
    if (trap) begin
      exp_rv   = 1'b1;
      exp_data = 32'd0;
      exp_err  = 1'b1;
      tick();
    end else begin
      tmo = 1'b1;
      exp_dreq = 1'b1;
      for (int c = 1; c <= TO; c++) begin
        if (c == k) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rd;
        end
        tick();
        bus.dmem_ack = 1'b0;
        if (c == k) begin
          tmo = 1'b0;
          break;
        end
      end
      exp_dreq = 1'b0;
      exp_rv   = 1'b1;
      exp_data = tmo ? 32'd0 : res;
      exp_err  = tmo;
      tick();
    end
    set_idle();
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.alucode    = '0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = '0;
    set_idle();
    clear_seen();
    #2;
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst dmem_we", 32'(bus.dmem_we), 32'd0);
    check("rst dmem_be", 32'(bus.dmem_be), 32'd0);
    check("rst dmem_addr", bus.dmem_addr, 32'd0);
    check("rst dmem_wdata", bus.dmem_wdata, 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_data", bus.resp_data, 32'd0);
    check("rst resp_err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;

    do_op(ALU_LW, 32'h0000_1004, 32'h0, 4, 32'hDEAD_BEEF);
    check("lw addr", seen_addr, 32'h0000_1004);
    check("lw be", 32'(seen_be), 32'hF);
    check("lw resp cycle", 32'(seen_rv_cyc), 32'd5);
    check("lw data", seen_data, 32'hDEAD_BEEF);
    check("lw err", 32'(seen_err), 32'd0);

    do_op(ALU_LB, 32'h0000_2003, 32'h0, 1, 32'h8011_2233);
    check("lb data", seen_data, 32'hFFFF_FF80);
    check("lb be", 32'(seen_be), 32'h8);
    check("lb resp cycle", 32'(seen_rv_cyc), 32'd2);
    do_op(ALU_LBU, 32'h0000_2003, 32'h0, 1, 32'h8011_2233);
    check("lbu data", seen_data, 32'h0000_0080);
    check("lbu be", 32'(seen_be), 32'h8);

    do_op(ALU_SH, 32'h0000_3002, 32'h1234_ABCD, 2, 32'h5555_5555);
    check("sh we", 32'(seen_we), 32'd1);
    check("sh be", 32'(seen_be), 32'hC);
    check("sh wdata", seen_wd, 32'hABCD_ABCD);
    check("sh data", seen_data, 32'd0);

    do_op(ALU_SB, 32'h0000_6001, 32'h0000_00A5, 3, 32'h0);
    do_op(ALU_LHU, 32'h0000_6002, 32'h0, 2, 32'hF00D_1234);
    do_op(ALU_LH, 32'h0000_6000, 32'h0, 1, 32'h1234_9ABC);

    do_op(ALU_LW, 32'h0000_4001, 32'h0, 1, 32'h0BAD_F00D);
`ifdef MEM_ALIGN_TRAP_EN
    check("mis resp cycle", 32'(seen_rv_cyc), 32'd1);
    check("mis err", 32'(seen_err), 32'd1);
    check("mis no req", 32'(dreq_cnt), 32'd0);
`else
    check("mask addr", seen_addr, 32'h0000_4000);
    check("mask data", seen_data, 32'h0BAD_F00D);
    check("mask err", 32'(seen_err), 32'd0);
`endif

    do_op(ALU_SW, 32'h0000_5000, 32'hCAFE_F00D, 0, 32'h0);
    check("tmo req cycles", 32'(dreq_cnt), 32'd4);
    check("tmo err", 32'(seen_err), 32'd1);
    check("tmo data", seen_data, 32'd0);
    clear_seen();
    tick();
    bus.dmem_ack = 1'b1;
    tick();
    bus.dmem_ack = 1'b0;
    tick();
    tick();
    check("late ack no resp", 32'(seen_rv_cyc), 32'hFFFF_FFFF);
    check("late ack no req", 32'(dreq_cnt), 32'd0);

    clear_seen();
    bus.req_valid = 1'b1;
    bus.alucode   = 6'd3;
    bus.addr      = 32'h0000_0100;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    check("non-mem ignored", 32'(dreq_cnt + (seen_rv_cyc + 1)), 32'd0);

    exp_we    = 1'b0;
    exp_be    = 4'hF;
    exp_daddr = 32'h0000_7000;
    exp_dwd   = 32'd0;
    bus.req_valid = 1'b1;
    bus.alucode   = ALU_LW;
    bus.addr      = 32'h0000_7000;
    bus.wdata     = 32'd0;
    tick();
    bus.req_valid = 1'b0;
    exp_ready = 1'b0;
    exp_dreq  = 1'b1;
    tick();
    chk_en = 1'b0;
    clear_seen();
    rst_n = 1'b0;
    #1;
    check("arst dmem_req", 32'(bus.dmem_req), 32'd0);
    check("arst req_ready", 32'(bus.req_ready), 32'd1);
    check("arst dmem_be", 32'(bus.dmem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    check("arst no resp", 32'(seen_rv_cyc), 32'hFFFF_FFFF);

    do_op(ALU_LH, 32'h0000_5002, 32'h0, 2, 32'h8765_4321);
    check("lh data", seen_data, 32'hFFFF_8765);
    check("lh be", 32'(seen_be), 32'hC);

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
